// File: rtl/pong_pkg.sv
// Shared state encoding and mode constants for the Pong match controller.
package pong_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StServeWait = 3'd1,
        StPlay      = 3'd2,
        StPaused    = 3'd3,
        StOver      = 3'd4
    } pong_state_e;

    localparam logic MODE_TIMED    = 1'b0;
    localparam logic MODE_FIRST_TO = 1'b1;

endpackage

// File: rtl/pong_countdown.sv
// Loadable down-counter that holds at zero; load wins over enable.
module pong_countdown #(
    parameter int unsigned         Width    = 8,
    parameter logic [Width-1:0]    ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic             zero_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= ResetVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match FSM: serve delay, play, pause, scoring, timed / first-to match end and
// winner resolution for NUM_PLAYERS players.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned SCORE_W       = 4,
    parameter int unsigned WIN_SCORE     = 7,
    parameter int unsigned SERVE_CYCLES  = 200,
    parameter int unsigned MATCH_SECONDS = 180,
    parameter int unsigned TIME_W        = 8,
    parameter int unsigned OVER_CYCLES   = 200
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           pause,
    input  logic                           mode,
    input  logic                           sec_tick,
    input  logic [NUM_PLAYERS-1:0]         miss,
    output logic                           stop,
    output logic                           serve,
    output logic [1:0]                     serve_to,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [TIME_W-1:0]              time_left,
    output logic [2:0]                     state,
    output logic [1:0]                     winner,
    output logic                           winner_valid,
    output logic                           tie
);

    localparam int unsigned        ServeW   = $clog2(SERVE_CYCLES + 1);
    localparam int unsigned        OverW    = $clog2(OVER_CYCLES + 1);
    localparam int unsigned        ScoresW  = NUM_PLAYERS * SCORE_W;
    localparam logic [SCORE_W-1:0] ScoreMax = '1;
    localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);

    pong_state_e        state_d, state_q;
    logic [1:0]         start_d, start_q;
    logic               mode_d, mode_q;
    logic [ScoresW-1:0] scores_d, scores_q;
    logic [1:0]         serve_to_d, serve_to_q;
    logic [1:0]         winner_d, winner_q;
    logic               winner_valid_d, winner_valid_q;
    logic               tie_d, tie_q;
    logic               stop_d, stop_q;
    logic               serve_d, serve_q;

    logic               start_edge, match_end, time_en;
    logic               serve_load, over_load, time_load;
    logic               serve_zero, over_zero, time_zero;
    logic [ServeW-1:0]  serve_cnt_unused;
    logic [OverW-1:0]   over_cnt_unused;
    logic [TIME_W-1:0]  time_cnt;
    logic [ScoresW-1:0] scores_upd;
    logic [SCORE_W-1:0] max_score;
    logic [1:0]         best_idx, miss_lo;
    logic [2:0]         n_at_max;
    logic               any_win;

    // Two-stage start history: the edge is acted on one cycle after it is seen.
    assign start_d    = {start_q[0], start};
    assign start_edge = start_q[0] & ~start_q[1];
    assign time_en    = (state_q == StPlay) && (mode_q == MODE_TIMED) && sec_tick;

    pong_countdown #(.Width(ServeW), .ResetVal('0)) u_serve_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (serve_load),
        .load_val_i(ServeW'(SERVE_CYCLES - 1)),
        .en_i      (state_q == StServeWait),
        .cnt_o     (serve_cnt_unused),
        .zero_o    (serve_zero)
    );

    pong_countdown #(.Width(TIME_W), .ResetVal(TIME_W'(MATCH_SECONDS))) u_time_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (time_load),
        .load_val_i(TIME_W'(MATCH_SECONDS)),
        .en_i      (time_en),
        .cnt_o     (time_cnt),
        .zero_o    (time_zero)
    );

    pong_countdown #(.Width(OverW), .ResetVal('0)) u_over_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (over_load),
        .load_val_i(OverW'(OVER_CYCLES - 1)),
        .en_i      (state_q == StOver),
        .cnt_o     (over_cnt_unused),
        .zero_o    (over_zero)
    );

    // Point rule: every player that did not miss gains a saturating point.
    always_comb begin
        scores_upd = scores_q;
        miss_lo    = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if ((|miss) && !miss[i] && (scores_q[i*SCORE_W +: SCORE_W] != ScoreMax)) begin
                scores_upd[i*SCORE_W +: SCORE_W] = scores_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
            end
        end
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (miss[i]) begin
                miss_lo = 2'(i);
            end
        end
    end

    // Max-scan over the post-update scores, captured on entry to OVER.
    always_comb begin
        max_score = '0;
        best_idx  = '0;
        n_at_max  = '0;
        any_win   = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (scores_upd[i*SCORE_W +: SCORE_W] > max_score) begin
                max_score = scores_upd[i*SCORE_W +: SCORE_W];
                best_idx  = 2'(i);
            end
            if (scores_upd[i*SCORE_W +: SCORE_W] >= WinScore) begin
                any_win = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (scores_upd[i*SCORE_W +: SCORE_W] == max_score) begin
                n_at_max = n_at_max + 3'd1;
            end
        end
    end

    assign match_end = (mode_q == MODE_FIRST_TO) ? any_win
                     : (time_zero || (sec_tick && (time_cnt == TIME_W'(1))));

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        scores_d       = scores_q;
        serve_to_d     = serve_to_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;
        tie_d          = tie_q;
        serve_load     = 1'b0;
        over_load      = 1'b0;
        time_load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    scores_d       = '0;
                    mode_d         = mode;
                    winner_valid_d = 1'b0;
                    tie_d          = 1'b0;
                    serve_to_d     = '0;
                    time_load      = 1'b1;
                    serve_load     = 1'b1;
                    state_d        = StServeWait;
                end
            end
            StServeWait: begin
                if (serve_zero) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                scores_d = scores_upd;
                if (|miss) begin
                    serve_to_d = miss_lo;
                end
                // A miss in the same cycle as a pause is scored; the pause waits for PLAY.
                if (match_end) begin
                    state_d        = StOver;
                    over_load      = 1'b1;
                    winner_d       = best_idx;
                    tie_d          = (n_at_max > 3'd1);
                    winner_valid_d = 1'b1;
                end else if (|miss) begin
                    state_d    = StServeWait;
                    serve_load = 1'b1;
                end else if (pause) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (!pause) begin
                    state_d = StPlay;
                end
            end
            StOver: begin
                if (over_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        stop_d  = (state_d != StPlay);
        serve_d = (state_q == StServeWait) && serve_zero;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            start_q        <= '0;
            mode_q         <= MODE_TIMED;
            scores_q       <= '0;
            serve_to_q     <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            tie_q          <= 1'b0;
            stop_q         <= 1'b1;
            serve_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            mode_q         <= mode_d;
            scores_q       <= scores_d;
            serve_to_q     <= serve_to_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
            tie_q          <= tie_d;
            stop_q         <= stop_d;
            serve_q        <= serve_d;
        end
    end

    assign stop         = stop_q;
    assign serve        = serve_q;
    assign serve_to     = serve_to_q;
    assign scores       = scores_q;
    assign time_left    = time_cnt;
    assign state        = state_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;
    assign tie          = tie_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed scenarios plus random play for pong_match_ctrl, every cycle compared
// against a cycle-stamped behavioural model of the match rules.
module tb_pong_match_ctrl;

    localparam int NP    = 2;
    localparam int SCW   = 4;
    localparam int WIN   = 3;
    localparam int SERVE = 4;
    localparam int MATCH = 5;
    localparam int OVERC = 8;
    localparam int TW    = 8;
    localparam int SMAX  = (1 << SCW) - 1;

    localparam int ST_IDLE   = 0;
    localparam int ST_SW     = 1;
    localparam int ST_PLAY   = 2;
    localparam int ST_PAUSED = 3;
    localparam int ST_OVER   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, pause = 1'b0, mode = 1'b0, sec_tick = 1'b0;
    logic [NP-1:0] miss = '0;
    logic stop, serve, winner_valid, tie;
    logic [1:0] serve_to, winner;
    logic [NP*SCW-1:0] scores;
    logic [TW-1:0] time_left;
    logic [2:0] state;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .NUM_PLAYERS  (NP),
        .SCORE_W      (SCW),
        .WIN_SCORE    (WIN),
        .SERVE_CYCLES (SERVE),
        .MATCH_SECONDS(MATCH),
        .TIME_W       (TW),
        .OVER_CYCLES  (OVERC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .mode        (mode),
        .sec_tick    (sec_tick),
        .miss        (miss),
        .stop        (stop),
        .serve       (serve),
        .serve_to    (serve_to),
        .scores      (scores),
        .time_left   (time_left),
        .state       (state),
        .winner      (winner),
        .winner_valid(winner_valid),
        .tie         (tie)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model: absolute cycle stamps for the serve and OVER deadlines.
    int m_state, m_time, m_serve_to, m_winner, cyc, serve_at, over_at;
    int m_scores[NP];
    bit m_mode, m_wv, m_tie, m_stop, m_serve, hist1, hist2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_time = MATCH; m_serve_to = 0; m_winner = 0;
        m_mode = 1'b0; m_wv = 1'b0; m_tie = 1'b0; m_stop = 1'b1; m_serve = 1'b0;
        hist1 = 1'b0; hist2 = 1'b0;
        foreach (m_scores[j]) m_scores[j] = 0;
    endtask

    task automatic model_step();
        int n = cyc + 1;
        bit edge_now = hist1 && !hist2;
        bit ended, found;
        int top, cnt;
        m_serve = 1'b0;
        case (m_state)
            ST_IDLE: if (edge_now) begin
                foreach (m_scores[j]) m_scores[j] = 0;
                m_time = MATCH; m_mode = mode; m_wv = 1'b0; m_tie = 1'b0; m_serve_to = 0;
                m_state = ST_SW; serve_at = n + SERVE;
            end
            ST_SW: if (n == serve_at) begin
                m_state = ST_PLAY; m_serve = 1'b1;
            end
            ST_PLAY: begin
                if (!m_mode && sec_tick) m_time = m_time - 1;
                if (miss != 0) begin
                    found = 1'b0;
                    for (int j = 0; j < NP; j++) begin
                        if (!miss[j]) m_scores[j] = (m_scores[j] >= SMAX) ? SMAX : m_scores[j] + 1;
                        if (miss[j] && !found) begin m_serve_to = j; found = 1'b1; end
                    end
                end
                top = 0;
                foreach (m_scores[j]) if (m_scores[j] > top) top = m_scores[j];
                ended = m_mode ? (top >= WIN) : (m_time == 0);
                if (ended) begin
                    cnt = 0; m_winner = -1;
                    for (int j = 0; j < NP; j++) begin
                        if (m_scores[j] == top) begin
                            cnt++;
                            if (m_winner < 0) m_winner = j;
                        end
                    end
                    m_tie = (cnt > 1); m_wv = 1'b1;
                    m_state = ST_OVER; over_at = n + OVERC;
                end else if (miss != 0) begin
                    m_state = ST_SW; serve_at = n + SERVE;
                end else if (pause) begin
                    m_state = ST_PAUSED;
                end
            end
            ST_PAUSED: if (!pause) m_state = ST_PLAY;
            ST_OVER: if (n == over_at) m_state = ST_IDLE;
            default: ;
        endcase
        m_stop = (m_state != ST_PLAY);
        hist2 = hist1; hist1 = start;
        cyc = n;
    endtask

    task automatic check_all(input string ph);
        logic [NP*SCW-1:0] exp_sc;
        exp_sc = '0;
        for (int j = 0; j < NP; j++) exp_sc[j*SCW +: SCW] = 4'(m_scores[j]);
        check_eq({ph, " state"}, 32'(state), 32'(m_state));
        check_eq({ph, " stop"}, 32'(stop), 32'(m_stop));
        check_eq({ph, " serve"}, 32'(serve), 32'(m_serve));
        check_eq({ph, " serve_to"}, 32'(serve_to), 32'(m_serve_to));
        check_eq({ph, " scores"}, 32'(scores), 32'(exp_sc));
        check_eq({ph, " time_left"}, 32'(time_left), 32'(m_time));
        check_eq({ph, " winner"}, 32'(winner), 32'(m_winner));
        check_eq({ph, " winner_valid"}, 32'(winner_valid), 32'(m_wv));
        check_eq({ph, " tie"}, 32'(tie), 32'(m_tie));
    endtask

    // Called at a falling edge: drive, advance the model, then compare at the next falling edge.
    task automatic step(input logic s, input logic p, input logic md, input logic t,
                        input logic [NP-1:0] ms);
        start = s; pause = p; mode = md; sec_tick = t; miss = ms;
        model_step();
        @(negedge clk);
        check_all("cycle");
    endtask

    task automatic wait_play(input string tag);
        int n = 0;
        while (m_state != ST_PLAY && n < 50) begin
            step(1'b0, 1'b0, mode, 1'($urandom), '0);
            n++;
        end
        check_eq({tag, " reached PLAY"}, 32'(state), ST_PLAY);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (m_state != ST_IDLE && n < 50) begin
            step(1'b0, 1'b0, mode, 1'b0, '0);
            n++;
        end
        check_eq({tag, " reached IDLE"}, 32'(state), ST_IDLE);
    endtask

    task automatic start_match(input logic md, input string tag);
        step(1'b0, 1'b0, md, 1'b0, '0);
        step(1'b1, 1'b0, md, 1'b0, '0);
        wait_play(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n_serve, n_sw, serve_idx, sw_idx;
        logic [2:0] prev;
        logic p;
        cyc = 0; serve_at = 0; over_at = 0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        // Start held high: one SERVE_WAIT entry, one serve four cycles later.
        n_serve = 0; n_sw = 0; serve_idx = 0; sw_idx = 0; prev = state;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, '0);
            if (serve) begin n_serve++; serve_idx = i; end
            if (state == 3'(ST_SW) && prev != 3'(ST_SW)) begin n_sw++; sw_idx = i; end
            prev = state;
        end
        check_eq("s1 serve pulses", 32'(n_serve), 1);
        check_eq("s1 serve_wait entries", 32'(n_sw), 1);
        check_eq("s1 serve delay", 32'(serve_idx - sw_idx), SERVE);
        check_eq("s1 stop in play", 32'(stop), 0);

        // First-to win by player 1.
        for (int k = 1; k <= 3; k++) begin
            wait_play("s2");
            step(1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
            check_eq("s2 p1 score", 32'(scores[7:4]), 32'(k));
            check_eq("s2 serve_to", 32'(serve_to), 0);
        end
        check_eq("s2 state over", 32'(state), ST_OVER);
        check_eq("s2 winner", 32'(winner), 1);
        check_eq("s2 tie", 32'(tie), 0);
        check_eq("s2 winner_valid", 32'(winner_valid), 1);
        for (int i = 0; i < OVERC - 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_eq("s2 still over", 32'(state), ST_OVER);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_eq("s2 idle after hold", 32'(state), ST_IDLE);

        // Timed tie.
        start_match(1'b0, "s3");
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        wait_play("s3");
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        wait_play("s3");
        for (int i = 0; i < MATCH; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check_eq("s3 scores", 32'(scores), 32'h11);
        check_eq("s3 time_left", 32'(time_left), 0);
        check_eq("s3 state over", 32'(state), ST_OVER);
        check_eq("s3 tie", 32'(tie), 1);
        check_eq("s3 winner", 32'(winner), 0);
        wait_idle("s3");

        // Pause suspends time and scoring.
        start_match(1'b0, "s4");
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check_eq("s4 paused", 32'(state), ST_PAUSED);
        step(1'b0, 1'b1, 1'b0, 1'b1, '0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
        step(1'b0, 1'b1, 1'b0, 1'b1, '0);
        check_eq("s4 time held", 32'(time_left), MATCH);
        check_eq("s4 scores held", 32'(scores), 0);
        check_eq("s4 stop", 32'(stop), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("s4 resumed", 32'(state), ST_PLAY);
        check_eq("s4 stop released", 32'(stop), 0);

        // Simultaneous events.
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        check_eq("s5 double miss scores", 32'(scores), 0);
        check_eq("s5 double miss serve_to", 32'(serve_to), 0);
        check_eq("s5 double miss state", 32'(state), ST_SW);
        wait_play("s5");
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        check_eq("s5 pause+miss state", 32'(state), ST_SW);
        check_eq("s5 pause+miss p1", 32'(scores[7:4]), 1);
        for (int i = 0; i < 20 && m_state == ST_SW; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check_eq("s5 pause honoured", 32'(state), ST_PAUSED);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < MATCH - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check_eq("s5 time one left", 32'(time_left), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        check_eq("s5 final scores", 32'(scores), 32'h11);
        check_eq("s5 state over", 32'(state), ST_OVER);
        check_eq("s5 no serve", 32'(serve), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("s5 still no serve", 32'(serve), 0);
        wait_idle("s5");

        // Saturation, then asynchronous reset mid-play.
        start_match(1'b0, "s6");
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
            wait_play("s6");
        end
        check_eq("s6 p0 saturated", 32'(scores[3:0]), SMAX);
        check_eq("s6 p1 zero", 32'(scores[7:4]), 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async reset");
        @(negedge clk);
        check_all("held reset");
        rst = 1'b1;

        // Random play.
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom_range(0, 7) == 0) ? ~pause : pause;
            step(($urandom_range(0, 15) == 0), p, 1'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
